// File: rtl/burst_fifo_pkg.sv
// Shared constants and helpers for the burst FIFO slice.
// Pulled in by the interface, the storage sub-module and the top.
package burst_fifo_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_DEPTH  = 16;

  // Pointer width for a power-of-two depth; never narrower than one bit.
  function automatic int ptr_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/burst_fifo_if.sv
// Push/pop handshake bundle between the burst FIFO and its neighbours.
// Status signals exist only when BURST_FIFO_STATUS_EN is defined.
interface burst_fifo_if
  import burst_fifo_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH
);

  logic              write_req;
  logic [DATA_W-1:0] write_data;
  logic              read_req;
  logic [DATA_W-1:0] read_data;
  logic              read_valid;
  logic              read_full;
  logic              read_empty;

`ifdef BURST_FIFO_STATUS_EN
  localparam int LEVEL_W = ptr_width(DEPTH) + 1;

  logic               overflow;
  logic               underflow;
  logic [LEVEL_W-1:0] level;

  modport master (
    output write_req, write_data, read_req,
    input  read_data, read_valid, read_full, read_empty,
    input  overflow, underflow, level
  );

  modport slave (
    input  write_req, write_data, read_req,
    output read_data, read_valid, read_full, read_empty,
    output overflow, underflow, level
  );
`else
  modport master (
    output write_req, write_data, read_req,
    input  read_data, read_valid, read_full, read_empty
  );

  modport slave (
    input  write_req, write_data, read_req,
    output read_data, read_valid, read_full, read_empty
  );
`endif

endinterface

// File: rtl/burst_fifo_mem.sv
// DEPTH x DATA_W simple dual-port storage: synchronous write port and a
// registered read port whose output register clears on reset.
module burst_fifo_mem
  import burst_fifo_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = ptr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it can map onto RAM; the pointers and
  // count in the controller are what make stale words unreachable.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Output register only moves on an accepted pop, so it holds between pops.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/burst_fifo.sv
// Burst FIFO controller: pointers, occupancy and registered flags around
// burst_fifo_mem. Optional status outputs under BURST_FIFO_STATUS_EN.
module burst_fifo
  import burst_fifo_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  burst_fifo_if.slave  bus
);

  localparam int ADDR_W = ptr_width(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_nxt;
  logic              full_q;
  logic              empty_q;
  logic              valid_q;
  logic              wr_ok;
  logic              rd_ok;
  logic [DATA_W-1:0] rd_data;

  // Acceptance uses the registered flags, so a pop never sees a word pushed
  // on the same edge and a push while full is dropped even if a pop frees
  // a slot in that cycle.
  assign wr_ok = bus.write_req & ~full_q;
  assign rd_ok = bus.read_req  & ~empty_q;

  // NOTE: combinational blocks give every output a default first so no
  // path through the case leaves a latch behind.
  always_comb begin
    count_nxt = count_q;
    unique case ({wr_ok, rd_ok})
      2'b10:   count_nxt = count_q + CNT_W'(1);
      2'b01:   count_nxt = count_q - CNT_W'(1);
      default: count_nxt = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      valid_q  <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      end
      if (rd_ok) begin
        rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      end
      count_q <= count_nxt;
      full_q  <= (count_nxt == CNT_W'(DEPTH));
      empty_q <= (count_nxt == '0);
      valid_q <= rd_ok;
    end
  end

  burst_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr_q),
    .wr_data (bus.write_data),
    .rd_en   (rd_ok),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  assign bus.read_data  = rd_data;
  assign bus.read_valid = valid_q;
  assign bus.read_full  = full_q;
  assign bus.read_empty = empty_q;

`ifdef BURST_FIFO_STATUS_EN
  logic overflow_q;
  logic underflow_q;

  // Sticky error bits: only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.write_req && full_q) begin
        overflow_q <= 1'b1;
      end
      if (bus.read_req && empty_q) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
  assign bus.level     = count_q;
`endif

endmodule

// File: tb/tb_burst_fifo.sv
// Directed self-checking bench for burst_fifo (DATA_W=8, DEPTH=16).
// Status outputs are checked only when BURST_FIFO_STATUS_EN is defined.
module tb_burst_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  burst_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  burst_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs set beforehand are sampled at the edge, outputs are
  // read 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst            = 1'b1;
    bus.write_req  = 1'b0;
    bus.write_data = '0;
    bus.read_req   = 1'b0;
    step();
    step();

    // Reset state.
    check("rst_empty", 32'(bus.read_empty), 32'd1);
    check("rst_full",  32'(bus.read_full),  32'd0);
    check("rst_valid", 32'(bus.read_valid), 32'd0);
    check("rst_data",  32'(bus.read_data),  32'h00);
`ifdef BURST_FIFO_STATUS_EN
    check("rst_ovf",   32'(bus.overflow),   32'd0);
    check("rst_udf",   32'(bus.underflow),  32'd0);
    check("rst_level", 32'(bus.level),      32'd0);
`endif
    rst = 1'b0;

    // Fill with 0x01..0x10.
    for (int i = 0; i < 16; i++) begin
      bus.write_req  = 1'b1;
      bus.write_data = 8'(i + 1);
      step();
      check("fill_empty", 32'(bus.read_empty), 32'd0);
      check("fill_full",  32'(bus.read_full),  (i == 15) ? 32'd1 : 32'd0);
    end

    // 17th push is dropped.
    bus.write_data = 8'hFF;
    step();
    check("ovf_full",  32'(bus.read_full),  32'd1);
    check("ovf_valid", 32'(bus.read_valid), 32'd0);
`ifdef BURST_FIFO_STATUS_EN
    check("ovf_flag",  32'(bus.overflow),   32'd1);
    check("ovf_level", 32'(bus.level),      32'd16);
`endif
    bus.write_req = 1'b0;

    // Drain 16 words in order; the 0xFF must not appear.
    bus.read_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      check("drain_valid", 32'(bus.read_valid), 32'd1);
      check("drain_data",  32'(bus.read_data),  32'(i + 1));
      check("drain_full",  32'(bus.read_full),  32'd0);
      check("drain_empty", 32'(bus.read_empty), (i == 15) ? 32'd1 : 32'd0);
    end

    // Read on empty is ignored.
    step();
    check("udf_valid", 32'(bus.read_valid), 32'd0);
    check("udf_data",  32'(bus.read_data),  32'h10);
    check("udf_empty", 32'(bus.read_empty), 32'd1);
`ifdef BURST_FIFO_STATUS_EN
    check("udf_flag",  32'(bus.underflow),  32'd1);
`endif
    bus.read_req = 1'b0;

    // Preload 5 words, then stream push+pop for 40 cycles across the wrap.
    bus.write_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.write_data = 8'(8'h20 + i);
      step();
    end
    bus.read_req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus.write_data = 8'(8'h25 + i);
      step();
      check("stream_valid", 32'(bus.read_valid), 32'd1);
      check("stream_data",  32'(bus.read_data),  32'(8'h20 + i));
      check("stream_empty", 32'(bus.read_empty), 32'd0);
      check("stream_full",  32'(bus.read_full),  32'd0);
`ifdef BURST_FIFO_STATUS_EN
      check("stream_level", 32'(bus.level),     32'd5);
`endif
    end
    bus.read_req = 1'b0;

    // Bring count to 9, then reset during a simultaneous push and pop.
    for (int i = 0; i < 4; i++) begin
      bus.write_data = 8'(8'h50 + i);
      step();
    end
    rst            = 1'b1;
    bus.write_req  = 1'b1;
    bus.read_req   = 1'b1;
    bus.write_data = 8'h77;
    step();
    rst           = 1'b0;
    bus.write_req = 1'b0;
    bus.read_req  = 1'b0;
    check("mrst_empty", 32'(bus.read_empty), 32'd1);
    check("mrst_full",  32'(bus.read_full),  32'd0);
    check("mrst_valid", 32'(bus.read_valid), 32'd0);
    check("mrst_data",  32'(bus.read_data),  32'h00);
`ifdef BURST_FIFO_STATUS_EN
    check("mrst_level", 32'(bus.level),      32'd0);
    check("mrst_ovf",   32'(bus.overflow),   32'd0);
    check("mrst_udf",   32'(bus.underflow),  32'd0);
`endif

    // Push 0xA5 then pop it back.
    bus.write_req  = 1'b1;
    bus.write_data = 8'hA5;
    step();
    bus.write_req = 1'b0;
    check("a5_push_empty", 32'(bus.read_empty), 32'd0);
    bus.read_req = 1'b1;
    step();
    bus.read_req = 1'b0;
    check("a5_valid", 32'(bus.read_valid), 32'd1);
    check("a5_data",  32'(bus.read_data),  32'hA5);
    check("a5_empty", 32'(bus.read_empty), 32'd1);

    // Push and pop together on empty: only the push completes.
    bus.write_req  = 1'b1;
    bus.write_data = 8'h5A;
    bus.read_req   = 1'b1;
    step();
    bus.write_req = 1'b0;
    check("wr_rd_empty_valid", 32'(bus.read_valid), 32'd0);
    check("wr_rd_empty_data",  32'(bus.read_data),  32'hA5);
    check("wr_rd_empty_empty", 32'(bus.read_empty), 32'd0);
    step();
    bus.read_req = 1'b0;
    check("pop_5a_valid", 32'(bus.read_valid), 32'd1);
    check("pop_5a_data",  32'(bus.read_data),  32'h5A);
    check("pop_5a_empty", 32'(bus.read_empty), 32'd1);

    // Fill again, then push+pop while full: pop completes, push dropped.
    bus.write_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.write_data = 8'(8'h60 + i);
      step();
    end
    check("refill_full", 32'(bus.read_full), 32'd1);
    bus.write_data = 8'hEE;
    bus.read_req   = 1'b1;
    step();
    bus.write_req = 1'b0;
    check("full_wr_rd_valid", 32'(bus.read_valid), 32'd1);
    check("full_wr_rd_data",  32'(bus.read_data),  32'h60);
    check("full_wr_rd_full",  32'(bus.read_full),  32'd0);
`ifdef BURST_FIFO_STATUS_EN
    check("full_wr_rd_level", 32'(bus.level),      32'd15);
`endif
    for (int i = 0; i < 15; i++) begin
      step();
      check("tail_data", 32'(bus.read_data), 32'(8'h61 + i));
    end
    check("tail_empty", 32'(bus.read_empty), 32'd1);
    step();
    bus.read_req = 1'b0;
    check("tail_over_valid", 32'(bus.read_valid), 32'd0);
    check("tail_over_data",  32'(bus.read_data),  32'h6F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
